// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings, FSM states and lane helpers for store_merge_unit
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Big-endian lanes: mask bit 3 is bits 31:24, i.e. byte offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b1000 >> lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] lo);
    store_misaligned = (size == SZ_RSVD) ||
                       ((size == SZ_HALF) && lo[0]) ||
                       ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// rtl/store_merge_unit_if.sv - request and memory-port bundle; mem_be exists only with STORE_BYTE_ENABLE_EN
interface store_merge_unit_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          start;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          misaligned;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0]    mem_be;

  modport master (
    output start, size, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );
  modport slave (
    input  start, size, addr, wdata, mem_rdata, mem_ready,
    output busy, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );
`else
  modport master (
    output start, size, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
  );
  modport slave (
    input  start, size, addr, wdata, mem_rdata, mem_ready,
    output busy, done, misaligned, mem_addr, mem_rd, mem_wr, mem_wdata
  );
`endif
endinterface

// File: rtl/store_merge_unit_lane_merge.sv
// rtl/store_merge_unit_lane_merge.sv - places a narrowed operand into its big-endian lanes of a word
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [31:0] placed_o,
  output logic [3:0]  be_o
);

  always_comb begin
    be_o = lane_mask(size_i, addr_lo_i);
    case (size_i)
      SZ_BYTE: placed_o = {4{wdata_i[7:0]}};
      SZ_HALF: placed_o = {2{wdata_i[15:0]}};
      default: placed_o = wdata_i;
    endcase
    // Replication puts the operand in every candidate lane; the mask picks the real one.
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) merged_o[8*i +: 8] = placed_o[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - sb/sh/sw store FSM with read-modify-write; STORE_BYTE_ENABLE_EN selects byte-enable writes
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic              clk,
  input logic              reset,
  store_merge_unit_if.slave bus
);

  state_e        state_q;
  logic [1:0]    size_q;
  logic [1:0]    lo_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic          done_q;
  logic          mis_q;
  logic [DW-1:0] merged_d;
  logic [DW-1:0] placed_d;
  logic [3:0]    be_d;

  lane_merge u_lane_merge (
    .old_word_i (bus.mem_rdata),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (lo_q),
    .merged_o   (merged_d),
    .placed_o   (placed_d),
    .be_o       (be_d)
  );

`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0] be_q;
  assign bus.mem_be = be_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
`ifdef STORE_BYTE_ENABLE_EN
      be_q        <= 4'b0000;
`endif
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            size_q     <= bus.size;
            lo_q       <= bus.addr[1:0];
            wdata_q    <= bus.wdata;
            mem_addr_q <= {bus.addr[AW-1:2], 2'b00};
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (store_misaligned(size_q, lo_q)) begin
            done_q  <= 1'b1;
            mis_q   <= 1'b1;
            state_q <= FIN;
`ifdef STORE_BYTE_ENABLE_EN
          end else begin
            mem_wdata_q <= placed_d;
            be_q        <= be_d;
            mem_wr_q    <= 1'b1;
            state_q     <= WRITE;
          end
`else
          end else if (size_q == SZ_WORD) begin
            mem_wdata_q <= placed_d;
            mem_wr_q    <= 1'b1;
            state_q     <= WRITE;
          end else begin
            mem_rd_q <= 1'b1;
            state_q  <= READ;
          end
`endif
        end
        READ: begin
          // mem_rdata is only trusted in the ready cycle, so merge and capture here.
          if (bus.mem_ready) begin
            mem_rd_q    <= 1'b0;
            mem_wdata_q <= merged_d;
            mem_wr_q    <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FIN;
`ifdef STORE_BYTE_ENABLE_EN
            be_q     <= 4'b0000;
`endif
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-path counterpart to the load-side sign extender in the multicycle datapath. It narrows the register operand to byte, half or word, then places it in the addressed lanes of a 32-bit memory word.
- Sub-word stores use read-modify-write on the word-wide data memory. Word stores write directly.
- Sits between the datapath store control and the data memory port. The controller holds in its MEM state until `done`.

Parameters:
- DW, 32: data/memory word width. Fixed lane logic; only 32 is supported.
- AW, 32: byte address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- size  in  2  00 byte (sb), 01 half (sh), 10 word (sw), 11 reserved (treated as misaligned).
- addr  in  AW  byte address of the store.
- wdata  in  DW  register operand; upper bits beyond size are discarded.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with `done`: 1 means the store was rejected and memory was untouched.
- mem_addr  out  AW  word address ({addr[AW-1:2],2'b00}), registered.
- mem_rd  out  1  read strobe, held until mem_ready.
- mem_wr  out  1  write strobe, held until mem_ready.
- mem_wdata  out  DW  merged word.
- mem_rdata  in  DW  read data, valid when mem_ready.
- mem_ready  in  1  memory completion for the current rd/wr.

Behaviour:
- Reset: state IDLE; busy, done, misaligned, mem_rd and mem_wr at 0; mem_addr and mem_wdata at 0.
- Capture: on start in IDLE, latch addr, size and wdata. Start while busy is ignored.
- Lane order is big-endian:
  - byte at addr[1:0]=k occupies bits [31-8k -: 8];
  - half at addr[1]=0 occupies [31:16], at addr[1]=1 occupies [15:0].
- Misalignment: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
- States and transitions:
  - IDLE → CHECK on start.
  - CHECK (1 cycle):
    - misaligned → FIN with misaligned=1;
    - word → WRITE with mem_wdata=wdata;
    - byte/half → READ.
  - READ: mem_rd=1. On mem_ready, merge mem_rdata with truncated wdata in the selected lanes; the other lanes are preserved bit-exact. Go to WRITE.
  - WRITE: mem_wr=1, mem_wdata stable. On mem_ready go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE. misaligned is held with done only.
- Latency with mem_ready returned same-cycle:
  - word: start→done = 3 cycles;
  - byte/half: 4 cycles;
  - misaligned: 2 cycles.
- mem_rd and mem_wr are never high together. Strobes stay asserted across wait cycles; mem_addr and mem_wdata do not change while a strobe is high.
- reset mid-operation returns the unit to IDLE next edge and drops strobes immediately (registered). No done pulse is produced for the aborted store.
- mem_ready outside READ/WRITE is ignored.

Optional Feature:
- Macro STORE_BYTE_ENABLE_EN.
- Defined:
  - adds output mem_be[3:0] (bit 3 = bits 31:24);
  - byte/half skip READ and go CHECK→WRITE with mem_wdata = truncated data replicated into all matching lanes, mem_be selecting the target lanes;
  - word uses mem_be=1111;
  - byte/half latency drops to 3 cycles;
  - mem_be is 0000 outside WRITE.
- Undefined: no mem_be port; read-modify-write as above.

Decomposition:
- Package store_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum IDLE/CHECK/READ/WRITE/FIN;
  - lane-mask function from size and addr[1:0].
- Sub-module lane_merge (combinational): inputs old word, wdata, size, addr[1:0]; outputs merged word and byte-enable mask. This is the inverse placement of the load extractor and is shared by both feature variants.

Test Plan:
- sb with addr=0x103, wdata=0xFFFFFFA5, mem_rdata=0x11223344 → one read at 0x100, write 0x112233A5, done at cycle 4, misaligned=0.
- sh with addr=0x202, wdata=0x0000BEEF, mem_rdata=0xCAFE0000, mem_ready delayed 3 cycles on each access → mem_wdata=0xCAFEBEEF; strobes held and stable through the waits; done once.
- sw with addr=0x300, wdata=0xDEADBEEF → no mem_rd, one write 0xDEADBEEF, done at cycle 3.
- sh with addr=0x201 (and sw with addr=0x302) → misaligned=1 with done at cycle 2; mem_rd/mem_wr never asserted.
- reset asserted during READ wait → next cycle IDLE, strobes 0, no done; a following sb completes normally.
- start pulsed while busy → ignored. With STORE_BYTE_ENABLE_EN defined: sb at addr=0x101 with wdata=0x7E → mem_be=0100, mem_wdata=0x7E7E7E7E, no read.
